// File: rtl/rf_port_ctrl.sv
// rf_port_ctrl
// Operand-fetch / write-back sequencer for the RV32I multi-cycle core. It is
// the only agent that drives the register file's address, data and write
// enable inputs.
//
// Sequence per instruction: IDLE (accept) -> READ (capture rs1/rs2 data) ->
// ISSUE (present operands) -> WAIT_RES (capture result) -> WRITE (commit).
//
// Optional feature macro: RF_FAST_WB_EN
//   defined   : req_ready is also high in WRITE; a request accepted there goes
//               straight to READ while the write commits at the same edge.
//   undefined : req_ready is high only in IDLE.
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready
// are both high; once valid is raised it stays high, with its data stable,
// until that transfer happens.
//
// Ports:
//   clock, reset             core clock; synchronous active-high reset
//   req_valid/req_ready      instruction handshake, req_instr = instruction word
//   op_valid/op_ready        operand handshake to execute, op_a/op_b = operands
//   res_valid/res_data/res_wen  result from execute
//   done                     one-cycle pulse when write-back completes
//   rf_rs1_addr/rf_rs2_addr  register file read addresses
//   rf_rs1_data/rf_rs2_data  asynchronous register file read data
//   rf_rd_addr/rf_rd_data/rf_we  register file write port
//   fsm_state                current FSM state (debug observation)

module rf_port_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_instr,
    output logic        req_ready,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        res_valid,
    input  logic [31:0] res_data,
    input  logic        res_wen,
    output logic        done,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    output logic [4:0]  rf_rd_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    output logic [31:0] rf_rd_data,
    output logic        rf_we,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_RES = 3'd3,
        S_WRITE    = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        accept;

    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic [31:0] res_q;
    logic        wen_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rs1_q <= req_instr[19:15];
                rs2_q <= req_instr[24:20];
                rd_q  <= req_instr[11:7];
            end
            if (state_q == S_READ) begin
                op_a_q <= rf_rs1_data;
                op_b_q <= rf_rs2_data;
            end
            // A res_valid seen in ISSUE (even alongside the operand
            // handshake) belongs to no instruction yet and is dropped.
            if (state_q == S_WAIT_RES && res_valid) begin
                res_q <= res_data;
                wen_q <= res_wen;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        req_ready = 1'b0;
        op_valid  = 1'b0;
        done      = 1'b0;
        rf_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    state_d = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (res_valid) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Gating with reset keeps an aborted instruction from
                // committing or signalling completion in the reset cycle.
                done    = ~reset;
                rf_we   = wen_q && (rd_q != 5'd0) && !reset;
                state_d = S_IDLE;
`ifdef RF_FAST_WB_EN
                // The new fields are latched at the commit edge; the commit
                // itself uses the values held during this cycle, and the new
                // READ happens after it, so read-after-write stays correct.
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = S_READ;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address and data outputs come straight from registers in every state.
    assign rf_rs1_addr = rs1_q;
    assign rf_rs2_addr = rs2_q;
    assign rf_rd_addr  = rd_q;
    assign rf_rd_data  = res_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_rf_port_ctrl.sv
// tb_rf_port_ctrl
// Self-checking bench for rf_port_ctrl. The bench plays the register file
// and the execute stage; a reference register array holds the architectural
// values the sequencer is expected to produce.
// Build with +define+RF_FAST_WB_EN to exercise the fast write-back variant.

module tb_rf_port_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_instr;
    logic        req_ready;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_wen;
    logic        done;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;
    logic [31:0] rf_rd_data;
    logic        rf_we;
    logic [2:0]  fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    rf_port_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_instr   (req_instr),
        .req_ready   (req_ready),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_wen     (res_wen),
        .done        (done),
        .rf_rs1_addr (rf_rs1_addr),
        .rf_rs2_addr (rf_rs2_addr),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .rf_rd_data  (rf_rd_data),
        .rf_we       (rf_we),
        .fsm_state   (fsm_state)
    );

    // ---------------- register file environment ----------------
    logic [31:0] rf     [32];
    logic [31:0] ref_rf [32];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          we_count = 0;

    always @(posedge clock) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (rf_we) rf[rf_rd_addr] <= rf_rd_data;
        if (rf_we) we_count <= we_count + 1;
    end

    // x0 is hardwired to zero on reads.
    assign rf_rs1_data = (rf_rs1_addr == 5'd0) ? 32'd0 : rf[rf_rs1_addr];
    assign rf_rs2_data = (rf_rs2_addr == 5'd0) ? 32'd0 : rf[rf_rs2_addr];

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_we   = 1'b0;
        ref_rf[a] = (a == 5'd0) ? 32'd0 : d;
    endtask

`ifdef RF_FAST_WB_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    bit skip_accept = 1'b0;

    // One full instruction. opd = cycles op_ready is withheld, resd = cycles
    // before the result arrives, junk = stray res_valid pulses during ISSUE,
    // chain = in the fast build, present next_instr during the WRITE cycle.
    task automatic run_instr(input logic [31:0] instr, input logic [31:0] data, input bit wen,
                             input int opd, input int resd, input bit junk,
                             input bit chain, input logic [31:0] next_instr);
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] ea;
        logic [31:0] eb;
        bit          exp_we;
        bit          chained;
        rs1 = instr[19:15];
        rs2 = instr[24:20];
        rd  = instr[11:7];
        if (!skip_accept) begin
            req_valid = 1'b1;
            req_instr = instr;
            check("req_ready_idle", {31'd0, req_ready}, 32'd1);
            step();
            req_valid = 1'b0;
        end
        skip_accept = 1'b0;
        // READ
        check("rs1_addr", {27'd0, rf_rs1_addr}, {27'd0, rs1});
        check("rs2_addr", {27'd0, rf_rs2_addr}, {27'd0, rs2});
        check("op_valid_read", {31'd0, op_valid}, 32'd0);
        ea = ref_rf[rs1];
        eb = ref_rf[rs2];
        step();
        // ISSUE with back-pressure
        for (int k = 0; k < opd; k++) begin
            op_ready = 1'b0;
            if (junk) begin
                res_valid = 1'b1;
                res_data  = $urandom;
                res_wen   = 1'b1;
            end
            check("op_valid_hold", {31'd0, op_valid}, 32'd1);
            check("op_a_hold", op_a, ea);
            check("op_b_hold", op_b, eb);
            check("rf_we_issue", {31'd0, rf_we}, 32'd0);
            step();
            res_valid = 1'b0;
        end
        op_ready = 1'b1;
        if (junk) begin
            res_valid = 1'b1;
            res_data  = $urandom;
            res_wen   = 1'b1;
        end
        check("op_valid", {31'd0, op_valid}, 32'd1);
        check("op_a", op_a, ea);
        check("op_b", op_b, eb);
        step();
        op_ready  = 1'b0;
        res_valid = 1'b0;
        // WAIT_RES
        check("op_valid_wait", {31'd0, op_valid}, 32'd0);
        for (int k = 0; k < resd; k++) begin
            check("done_early", {31'd0, done}, 32'd0);
            check("rf_we_wait", {31'd0, rf_we}, 32'd0);
            step();
        end
        res_valid = 1'b1;
        res_data  = data;
        res_wen   = wen;
        check("done_wait", {31'd0, done}, 32'd0);
        step();
        res_valid = 1'b0;
        res_data  = $urandom;
        // WRITE
        exp_we = wen && (rd != 5'd0);
        check("done", {31'd0, done}, 32'd1);
        check("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
        if (exp_we) begin
            check("rf_rd_addr", {27'd0, rf_rd_addr}, {27'd0, rd});
            check("rf_rd_data", rf_rd_data, data);
            ref_rf[rd] = data;
        end
        check("req_ready_write", {31'd0, req_ready}, {31'd0, FAST});
        chained = FAST && chain;
        if (chained) begin
            req_valid   = 1'b1;
            req_instr   = next_instr;
            skip_accept = 1'b1;
        end
        step();
        req_valid = 1'b0;
        check("done_after", {31'd0, done}, 32'd0);
        check("rf_we_after", {31'd0, rf_we}, 32'd0);
        if (!chained) check("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    // Abort an instruction with reset in WAIT_RES (in_write=0) or WRITE.
    task automatic reset_at(input bit in_write);
        int          wc;
        logic [4:0]  rd;
        rd = 5'd5;
        req_valid = 1'b1;
        req_instr = mk(rd, 5'd1, 5'd2);
        step();
        req_valid = 1'b0;
        step();                 // READ -> ISSUE
        op_ready = 1'b1;
        step();                 // ISSUE -> WAIT_RES
        op_ready = 1'b0;
        wc = we_count;
        res_valid = 1'b1;
        res_data  = 32'hA5A5_0001;
        res_wen   = 1'b1;
        if (in_write) begin
            step();
            res_valid = 1'b0;
            check("rst_pre_done", {31'd0, done}, 32'd1);
        end
        reset = 1'b1;
        #1;
        check("rst_cycle_done", {31'd0, done}, 32'd0);
        check("rst_cycle_we", {31'd0, rf_we}, 32'd0);
        step();
        reset     = 1'b0;
        res_valid = 1'b0;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_op_valid", {31'd0, op_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rd_addr", {27'd0, rf_rd_addr}, 32'd0);
        check("rst_op_a", op_a, 32'd0);
        step();
        check("rst_we_count", we_count, wc);
        check("rst_target", rf[rd], ref_rf[rd]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] cur;
        logic [31:0] nxt;
        bit          ch;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_instr = '0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        res_wen   = 1'b0;
        for (int i = 0; i < 32; i++) preload(i[4:0], $urandom);
        step();
        step();
        check("rst_hold_ready", {31'd0, req_ready}, 32'd1);
        reset = 1'b0;
        step();
        // reset values
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_op_valid", {31'd0, op_valid}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_rf_we", {31'd0, rf_we}, 32'd0);
        check("reset_addrs", {17'd0, rf_rs1_addr, rf_rs2_addr, rf_rd_addr}, 32'd0);
        check("reset_rd_data", rf_rd_data, 32'd0);
        check("reset_op_a", op_a, 32'd0);
        check("reset_op_b", op_b, 32'd0);

        // basic ADD x3 = x1 + x2
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        run_instr(32'h002081B3, 32'd12, 1'b1, 0, 0, 1'b0, 1'b0, 32'd0);
        check("add_x3", rf[3], 32'd12);

        // x0 write suppression, then read x0
        run_instr(mk(5'd0, 5'd1, 5'd2), 32'hDEADBEEF, 1'b1, 0, 0, 1'b0, 1'b0, 32'd0);
        run_instr(mk(5'd4, 5'd0, 5'd0), 32'd1, 1'b0, 0, 1, 1'b0, 1'b0, 32'd0);

        // back-pressure: op_ready withheld for 6 cycles, stray res_valid
        run_instr(mk(5'd6, 5'd1, 5'd2), 32'd99, 1'b1, 6, 0, 1'b1, 1'b0, 32'd0);

        // RAW chain: write x3, then immediately read it
        run_instr(mk(5'd3, 5'd1, 5'd2), 32'h0000_1234, 1'b1, 0, 0, 1'b0, 1'b1, mk(5'd7, 5'd3, 5'd3));
        run_instr(mk(5'd7, 5'd3, 5'd3), 32'h0000_2468, 1'b1, 0, 0, 1'b0, 1'b0, 32'd0);

        // reset mid-operation
        reset_at(1'b0);
        reset_at(1'b1);

        // randomized instruction stream
        cur = $urandom;
        for (int i = 0; i < 40; i++) begin
            nxt = $urandom;
            ch  = (i != 39) && ($urandom_range(0, 1) == 1);
            run_instr(cur, $urandom, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 1) == 1, ch, nxt);
            cur = nxt;
        end

        // final architectural state
        for (int i = 1; i < 32; i++) check($sformatf("final_x%0d", i), rf[i], ref_rf[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
